// File: rtl/led_dev.sv
// led_dev: memory-mapped LED output, pattern FIFO plus hold-time pacing.
// Optional build macro LED_FLUSH_EN enables the CTRL flush bit.
module led_dev #(
  parameter int DBITS = 32,
  parameter int CTRLBITS = 9,
  parameter int CTRL_RDY = 0,
  parameter int CTRL_FLUSH = 1,
  parameter int CTRL_OVR = 2,
  parameter int CTRL_IE = 8,
  parameter logic [DBITS-1:0] LEDDATAADDR = 32'hFFFFF080,
  parameter logic [DBITS-1:0] LEDCTRLADDR = 32'hFFFFF084,
  parameter int LEDDATABITS = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld,
  input  logic                   sw,
  input  logic [DBITS-1:0]       addrbus,
  inout  wire  [DBITS-1:0]       databus,
  output logic [LEDDATABITS-1:0] LEDR,
  output logic                   LEDIRQ
);

  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = 3;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t state;
  state_t state_d;

  logic [HW-1:0] hold;
  logic [HW-1:0] hold_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [LEDDATABITS-1:0] mem [FIFO_DEPTH];

  logic ovr;
  logic ie;
  logic rdy;
  logic full;

  logic data_sel;
  logic ctrl_sel;
  logic data_wr;
  logic ctrl_wr;
  logic push;
  logic pop;
  logic deq;
  logic flush;

  logic [CTRLBITS-1:0] ctrl;
  logic [DBITS-1:0]    rdata;
  logic                unused_bus;

  assign data_sel = (addrbus == LEDDATAADDR);
  assign ctrl_sel = (addrbus == LEDCTRLADDR);
  assign data_wr  = sw & data_sel;
  assign ctrl_wr  = sw & ctrl_sel;

  assign full = (cnt == DEPTH);
  assign rdy  = (cnt < DEPTH);

  // full test uses the pre-edge count, so a same-edge pop never frees a slot
  assign push = data_wr & ~full;

`ifdef LED_FLUSH_EN
  assign flush = ctrl_wr & databus[CTRL_FLUSH];
`else
  assign flush = 1'b0;
`endif

  assign deq = pop & ~flush;

  assign unused_bus = ^databus;

  always_comb begin
    state_d = state;
    hold_d  = hold;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cnt != '0) begin
          pop     = 1'b1;
          hold_d  = HOLD_LD;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold != '0) begin
          hold_d = hold - 1'b1;
        end else if (cnt != '0) begin
          pop    = 1'b1;
          hold_d = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end
  end

  always_comb begin
    cnt_d = cnt;
    unique case ({push, deq})
      2'b10:   cnt_d = cnt + 1'b1;
      2'b01:   cnt_d = cnt - 1'b1;
      default: cnt_d = cnt;
    endcase
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= databus[LEDDATABITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LEDR <= '0;
    end else if (deq) begin
      LEDR <= mem[rd_ptr];
    end
  end

  // writing 1 to OVR keeps it, writing 0 clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr <= 1'b0;
      ie  <= 1'b0;
    end else if (ctrl_wr) begin
      ie  <= databus[CTRL_IE];
      ovr <= ovr & databus[CTRL_OVR];
    end else if (data_wr && full) begin
      ovr <= 1'b1;
    end
  end

  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_RDY]   = rdy;
    ctrl[CTRL_FLUSH] = 1'b0;
    ctrl[CTRL_OVR]   = ovr;
    ctrl[6:4]        = cnt;
    ctrl[CTRL_IE]    = ie;
  end

  assign LEDIRQ = ctrl[CTRL_RDY] & ctrl[CTRL_IE];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      data_sel: rdata = DBITS'(LEDR);
      ctrl_sel: rdata = DBITS'(ctrl);
      default:  rdata = '0;
    endcase
  end

  assign databus = (ld && (data_sel || ctrl_sel)) ? rdata : 'z;

endmodule

// File: tb/tb_led_dev.sv
// tb_led_dev: directed plus random bus traffic against a queue/timestamp
// model of the LED FIFO and pacing behaviour.
module tb_led_dev;

  localparam int H = 4;
  localparam int DEPTH = 4;
  localparam logic [31:0] DA = 32'hFFFFF080;
  localparam logic [31:0] CA = 32'hFFFFF084;
  localparam logic [31:0] XA = 32'hFFFFF088;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld;
  logic        sw;
  logic [31:0] addrbus;
  wire  [31:0] databus;
  logic [31:0] tb_drv;
  logic        tb_oe;
  logic [9:0]  LEDR;
  logic        LEDIRQ;

  assign databus = tb_oe ? tb_drv : 'z;

  always #5 clk = ~clk;

  led_dev #(
    .HOLD_CYCLES(H),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld(ld),
    .sw(sw),
    .addrbus(addrbus),
    .databus(databus),
    .LEDR(LEDR),
    .LEDIRQ(LEDIRQ)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] q[$];
  logic [9:0] m_led;
  logic       m_ovr;
  logic       m_ie;
  int         t;
  int         next_free;

  function automatic logic [31:0] m_ctrl();
    int n;
    n = q.size();
    return 32'(n < DEPTH) | (32'(m_ovr) << 2) | (32'(n) << 4) | (32'(m_ie) << 8);
  endfunction

  function automatic logic m_irq();
    return m_ie && (q.size() < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_led = '0;
    m_ovr = 1'b0;
    m_ie = 1'b0;
    next_free = 0;
  endtask

  // a pattern shown at edge L may be replaced no earlier than edge L+H
  task automatic model_edge(input logic s, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit fl;
    n = q.size();
    fl = 1'b0;
`ifdef LED_FLUSH_EN
    fl = s && (a == CA) && d[1];
`endif
    if (fl) begin
      q.delete();
      next_free = t;
    end else if (n > 0 && t >= next_free) begin
      m_led = q.pop_front();
      next_free = t + H;
    end
    if (s && a == DA) begin
      if (n < DEPTH) q.push_back(d[9:0]);
      else m_ovr = 1'b1;
    end
    if (s && a == CA) begin
      m_ie = d[8];
      if (!d[2]) m_ovr = 1'b0;
    end
    t++;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ld = 1'b1;
    addrbus = a;
    #1;
    chk(tag, databus, exp);
    ld = 1'b0;
    addrbus = '0;
  endtask

  task automatic step(input logic s, input logic [31:0] a, input logic [31:0] d);
    ld = 1'b0;
    sw = s;
    addrbus = a;
    tb_drv = d;
    tb_oe = s;
    model_edge(s, a, d);
    @(posedge clk);
    #1;
    sw = 1'b0;
    tb_oe = 1'b0;
    addrbus = '0;
    chk("ledr", 32'(LEDR), 32'(m_led));
    chk("irq", 32'(LEDIRQ), 32'(m_irq()));
    rd("ctrl", CA, m_ctrl());
    rd("data", DA, 32'(m_led));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  initial begin
    int r;
    reset = 1'b0;
    ld = 1'b0;
    sw = 1'b0;
    addrbus = '0;
    tb_drv = '0;
    tb_oe = 1'b0;
    t = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ledr", 32'(LEDR), 32'h0);
    chk("rst_irq", 32'(LEDIRQ), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd("rst_ctrl", CA, 32'h001);
    rd("rst_data", DA, 32'h000);

    // single write
    step(1'b1, DA, 32'h155);
    chk("single_pre", 32'(LEDR), 32'h000);
    step(1'b0, '0, '0);
    chk("single_show", 32'(LEDR), 32'h155);
    idle(8);
    chk("single_held", 32'(LEDR), 32'h155);
    rd("single_ctrl", CA, 32'h001);

    // queue and pacing
    step(1'b1, DA, 32'h001);
    step(1'b1, DA, 32'h002);
    step(1'b1, DA, 32'h003);
    rd("queue_peak", CA, 32'h021);
    idle(16);
    chk("queue_last", 32'(LEDR), 32'h003);

    // overflow
    for (int i = 0; i < 6; i++) step(1'b1, DA, 32'h010 + 32'(i));
    rd("ovf_ctrl", CA, 32'h035);
    idle(24);
    chk("ovf_last", 32'(LEDR), 32'h014);
    step(1'b1, CA, 32'h000);
    rd("ovf_clr", CA, 32'h001);

    // interrupt
    step(1'b1, CA, 32'h100);
    chk("irq_on", 32'(LEDIRQ), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, DA, 32'h020 + 32'(i));
    chk("irq_full", 32'(LEDIRQ), 32'h0);
    step(1'b0, '0, '0);
    chk("irq_pop", 32'(LEDIRQ), 32'h1);
    idle(24);

`ifdef LED_FLUSH_EN
    step(1'b1, DA, 32'h0A1);
    step(1'b1, DA, 32'h0A2);
    step(1'b1, DA, 32'h0A3);
    step(1'b0, '0, '0);
    step(1'b1, CA, 32'h002);
    rd("flush_ctrl", CA, 32'h001);
    idle(10);
    chk("flush_held", 32'(LEDR), 32'h0A1);
`endif

    // reset mid-hold drops queued data
    step(1'b1, DA, 32'h0C1);
    step(1'b1, DA, 32'h0C2);
    step(1'b1, DA, 32'h0C3);
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ledr", 32'(LEDR), 32'h0);
    chk("mid_rst_irq", 32'(LEDIRQ), 32'h0);
    rd("mid_rst_ctrl", CA, 32'h001);
    @(negedge clk);
    reset = 1'b1;
    idle(6);
    chk("mid_rst_lost", 32'(LEDR), 32'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35) step(1'b1, DA, $urandom());
      else if (r < 42) step(1'b1, CA, $urandom());
      else if (r < 46) step(1'b1, XA, $urandom());
      else step(1'b0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
